// File: rtl/stream_pattern_gen.sv
// Register-programmable video stream source. Emits pixel/dv/sop/eop streams framed by blanking
// intervals; frame geometry, pixel rate and pattern are latched into shadow registers at every
// frame start, so register writes never disturb a frame in flight.
module stream_pattern_gen #(
    parameter int unsigned PIXEL_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEFAULT_SCR    = 0,
    parameter int unsigned DEFAULT_COLS   = 320,
    parameter int unsigned DEFAULT_ROWS   = 10,
    parameter int unsigned DEFAULT_HBLANK = 100,
    parameter int unsigned DEFAULT_VBLANK = 23,
    parameter int unsigned DEFAULT_DIV    = 6
) (
    input  logic                   clk_proc,
    input  logic                   reset_n,
    output logic [PIXEL_WIDTH-1:0] out_data,
    output logic                   out_dv,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic                   out_fv,
    input  logic [2:0]             addr_rel_i,
    input  logic                   wr_i,
    input  logic [DATA_WIDTH-1:0]  datawr_i,
    input  logic                   rd_i,
    output logic [DATA_WIDTH-1:0]  datard_o
);

    localparam logic [3:0]  DefScr    = 4'(DEFAULT_SCR);
    localparam logic [15:0] DefCols   = 16'(DEFAULT_COLS);
    localparam logic [15:0] DefRows   = 16'(DEFAULT_ROWS);
    localparam logic [15:0] DefHblank = 16'(DEFAULT_HBLANK);
    localparam logic [15:0] DefVblank = 16'(DEFAULT_VBLANK);
    localparam logic [7:0]  DefDiv    = 8'(DEFAULT_DIV);
    localparam logic [15:0] LfsrSeed  = 16'hACE1;
    // Galois feedback mask for taps 16,14,13,11
    localparam logic [15:0] LfsrTaps  = 16'hB400;

    typedef enum logic [2:0] {StIdle, StVpre, StHpre, StActive, StHblank, StVpost} state_e;

    state_e state_q, state_d, first_state;

    // Programming registers
    logic                   scr_enable_q, scr_enable_d;
    logic                   scr_cont_q, scr_cont_d;
    logic [1:0]             scr_mode_q, scr_mode_d;
    logic                   cfg_err_q, cfg_err_d;
    logic [15:0]            cols_q, cols_d, rows_q, rows_d;
    logic [15:0]            hblank_q, hblank_d, vblank_q, vblank_d;
    logic [7:0]             div_q, div_d;
    logic [PIXEL_WIDTH-1:0] const_q, const_d;
    logic [31:0]            frames_q, frames_d;
    logic [DATA_WIDTH-1:0]  datard_q, datard_d, rd_val;

    // Per-frame shadow copies
    logic [15:0]            cols_s_q, cols_s_d, rows_s_q, rows_s_d;
    logic [15:0]            hb_s_q, hb_s_d, vb_s_q, vb_s_d;
    logic [7:0]             div_s_q, div_s_d;
    logic [1:0]             mode_s_q, mode_s_d;
    logic [PIXEL_WIDTH-1:0] const_s_q, const_s_d;

    // Timing and pattern state
    logic [7:0]             div_cnt_q, div_cnt_d, div_eff;
    logic [15:0]            cnt_q, cnt_d, row_q, row_d, state_len;
    logic [PIXEL_WIDTH-1:0] ramp_q, ramp_d;
    logic [15:0]            lfsr_q, lfsr_d;

    // Registered stream outputs
    logic [PIXEL_WIDTH-1:0] data_q, data_d;
    logic                   dv_q, dv_d, sop_q, sop_d, eop_q, eop_d, fv_q, fv_d;

    logic tick, cnt_last, step_done, row_last, cfg_bad, pix_fire;
    logic frame_start, frame_done, cfg_fault;
    logic unused_wr;

    assign unused_wr = ^datawr_i[DATA_WIDTH-1:16];

    assign div_eff   = (div_s_q == 8'd0) ? 8'd1 : div_s_q;
    assign tick      = (state_q != StIdle) && (div_cnt_q == div_eff - 8'd1);
    assign cnt_last  = (cnt_q == state_len - 16'd1);
    assign step_done = tick && cnt_last;
    assign row_last  = (row_q == rows_s_q - 16'd1);
    assign cfg_bad   = (cols_q == 16'd0) || (rows_q == 16'd0);
    assign pix_fire  = tick && (state_q == StActive);

    // Length in ticks of the current state, taken from the frame's shadow copy
    always_comb begin
        state_len = 16'd1;
        case (state_q)
            StVpre, StVpost:  state_len = vb_s_q;
            StHpre, StHblank: state_len = hb_s_q;
            StActive:         state_len = cols_s_q;
            default:          state_len = 16'd1;
        endcase
    end

    // Entry state of a new frame, skipping zero-length blanking (uses live registers)
    always_comb begin
        if (vblank_q != 16'd0) begin
            first_state = StVpre;
        end else if (hblank_q != 16'd0) begin
            first_state = StHpre;
        end else begin
            first_state = StActive;
        end
    end

    // FSM state register
    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state, plus frame start/end and configuration fault events
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        cfg_fault   = 1'b0;
        case (state_q)
            StIdle: begin
                if (scr_enable_q) begin
                    if (cfg_bad) begin
                        cfg_fault = 1'b1;
                    end else begin
                        frame_start = 1'b1;
                        state_d     = first_state;
                    end
                end
            end
            StVpre: begin
                if (step_done) begin
                    state_d = (hb_s_q != 16'd0) ? StHpre : StActive;
                end
            end
            StHpre: begin
                if (step_done) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (step_done) begin
                    if (hb_s_q != 16'd0) begin
                        state_d = StHblank;
                    end else if (!row_last) begin
                        state_d = StActive;
                    end else if (vb_s_q != 16'd0) begin
                        state_d = StVpost;
                    end else begin
                        frame_done = 1'b1;
                    end
                end
            end
            StHblank: begin
                if (step_done) begin
                    if (!row_last) begin
                        state_d = StActive;
                    end else if (vb_s_q != 16'd0) begin
                        state_d = StVpost;
                    end else begin
                        frame_done = 1'b1;
                    end
                end
            end
            StVpost: begin
                if (step_done) begin
                    frame_done = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // End of frame: restart immediately in continuous mode, otherwise park in idle
        if (frame_done) begin
            if (scr_enable_q && scr_cont_q) begin
                if (cfg_bad) begin
                    cfg_fault = 1'b1;
                    state_d   = StIdle;
                end else begin
                    frame_start = 1'b1;
                    state_d     = first_state;
                end
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Tick divider, tick/row counters, shadow latch and pattern generators
    always_comb begin
        div_cnt_d = div_cnt_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        ramp_d    = ramp_q;
        lfsr_d    = lfsr_q;
        cols_s_d  = cols_s_q;
        rows_s_d  = rows_s_q;
        hb_s_d    = hb_s_q;
        vb_s_d    = vb_s_q;
        div_s_d   = div_s_q;
        mode_s_d  = mode_s_q;
        const_s_d = const_s_q;

        if (frame_start || state_q == StIdle) begin
            div_cnt_d = 8'd0;
            cnt_d     = 16'd0;
        end else begin
            div_cnt_d = (div_cnt_q >= div_eff - 8'd1) ? 8'd0 : div_cnt_q + 8'd1;
            if (tick) begin
                cnt_d = cnt_last ? 16'd0 : cnt_q + 16'd1;
            end
        end

        // A line is complete once its trailing blanking (if any) has elapsed
        if (step_done && ((state_q == StActive && hb_s_q == 16'd0) || state_q == StHblank)) begin
            row_d = row_q + 16'd1;
        end

        if (pix_fire) begin
            ramp_d = ramp_q + 1'b1;
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
        end

        // Frame start wins over the last pixel step of a back-to-back previous frame
        if (frame_start) begin
            row_d     = 16'd0;
            ramp_d    = '0;
            lfsr_d    = LfsrSeed;
            cols_s_d  = cols_q;
            rows_s_d  = rows_q;
            hb_s_d    = hblank_q;
            vb_s_d    = vblank_q;
            div_s_d   = div_q;
            mode_s_d  = scr_mode_q;
            const_s_d = const_q;
        end
    end

    // Timing, shadow and pattern state
    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= 8'd0;
            cnt_q     <= 16'd0;
            row_q     <= 16'd0;
            ramp_q    <= '0;
            lfsr_q    <= LfsrSeed;
            cols_s_q  <= DefCols;
            rows_s_q  <= DefRows;
            hb_s_q    <= DefHblank;
            vb_s_q    <= DefVblank;
            div_s_q   <= DefDiv;
            mode_s_q  <= DefScr[3:2];
            const_s_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            ramp_q    <= ramp_d;
            lfsr_q    <= lfsr_d;
            cols_s_q  <= cols_s_d;
            rows_s_q  <= rows_s_d;
            hb_s_q    <= hb_s_d;
            vb_s_q    <= vb_s_d;
            div_s_q   <= div_s_d;
            mode_s_q  <= mode_s_d;
            const_s_q <= const_s_d;
        end
    end

    // Stream outputs, one clock after the tick that produced the pixel
    always_comb begin
        dv_d   = pix_fire;
        sop_d  = pix_fire && (row_q == 16'd0) && (cnt_q == 16'd0);
        eop_d  = pix_fire && row_last && cnt_last;
        fv_d   = (state_q == StHpre) || (state_q == StActive) || (state_q == StHblank);
        data_d = '0;
        if (pix_fire) begin
            unique case (mode_s_q)
                2'd0: data_d = ramp_q;
                2'd1: data_d = lfsr_q[PIXEL_WIDTH-1:0];
                2'd2: data_d = cnt_q[PIXEL_WIDTH-1:0];
                2'd3: data_d = const_s_q;
            endcase
        end
    end

    // Stream output registers
    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
            dv_q   <= 1'b0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
            fv_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            dv_q   <= dv_d;
            sop_q  <= sop_d;
            eop_q  <= eop_d;
            fv_q   <= fv_d;
        end
    end

    assign out_data = data_q;
    assign out_dv   = dv_q;
    assign out_sop  = sop_q;
    assign out_eop  = eop_q;
    assign out_fv   = fv_q;

    // Register writes; FSM-side updates (auto-clear, error flag) override the bus
    always_comb begin
        scr_enable_d = scr_enable_q;
        scr_cont_d   = scr_cont_q;
        scr_mode_d   = scr_mode_q;
        cfg_err_d    = cfg_err_q;
        cols_d       = cols_q;
        rows_d       = rows_q;
        hblank_d     = hblank_q;
        vblank_d     = vblank_q;
        div_d        = div_q;
        const_d      = const_q;
        frames_d     = frames_q + {31'd0, frame_done};
        if (wr_i) begin
            unique case (addr_rel_i)
                3'd0: begin
                    scr_enable_d = datawr_i[0];
                    scr_cont_d   = datawr_i[1];
                    scr_mode_d   = datawr_i[3:2];
                    if (datawr_i[4]) begin
                        cfg_err_d = 1'b0;
                    end
                end
                3'd1: cols_d   = datawr_i[15:0];
                3'd2: rows_d   = datawr_i[15:0];
                3'd3: hblank_d = datawr_i[15:0];
                3'd4: vblank_d = datawr_i[15:0];
                3'd5: div_d    = datawr_i[7:0];
                3'd6: const_d  = datawr_i[PIXEL_WIDTH-1:0];
                3'd7: frames_d = 32'd0;
            endcase
        end
        if (frame_done && !scr_cont_q) begin
            scr_enable_d = 1'b0;
        end
        if (cfg_fault) begin
            scr_enable_d = 1'b0;
            cfg_err_d    = 1'b1;
        end
    end

    // Read mux; sampled from current register values so a same-cycle write reads old data
    always_comb begin
        rd_val = '0;
        unique case (addr_rel_i)
            3'd0: rd_val[4:0]             = {cfg_err_q, scr_mode_q, scr_cont_q, scr_enable_q};
            3'd1: rd_val[15:0]            = cols_q;
            3'd2: rd_val[15:0]            = rows_q;
            3'd3: rd_val[15:0]            = hblank_q;
            3'd4: rd_val[15:0]            = vblank_q;
            3'd5: rd_val[7:0]             = div_q;
            3'd6: rd_val[PIXEL_WIDTH-1:0] = const_q;
            3'd7: rd_val                  = DATA_WIDTH'(frames_q);
        endcase
        datard_d = rd_i ? rd_val : datard_q;
    end

    // Register file and read data
    always_ff @(posedge clk_proc or negedge reset_n) begin
        if (!reset_n) begin
            scr_enable_q <= DefScr[0];
            scr_cont_q   <= DefScr[1];
            scr_mode_q   <= DefScr[3:2];
            cfg_err_q    <= 1'b0;
            cols_q       <= DefCols;
            rows_q       <= DefRows;
            hblank_q     <= DefHblank;
            vblank_q     <= DefVblank;
            div_q        <= DefDiv;
            const_q      <= '0;
            frames_q     <= 32'd0;
            datard_q     <= '0;
        end else begin
            scr_enable_q <= scr_enable_d;
            scr_cont_q   <= scr_cont_d;
            scr_mode_q   <= scr_mode_d;
            cfg_err_q    <= cfg_err_d;
            cols_q       <= cols_d;
            rows_q       <= rows_d;
            hblank_q     <= hblank_d;
            vblank_q     <= vblank_d;
            div_q        <= div_d;
            const_q      <= const_d;
            frames_q     <= frames_d;
            datard_q     <= datard_d;
        end
    end

    assign datard_o = datard_q;

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed bench for stream_pattern_gen: streams are captured by a negedge monitor into queues and
// checked against hand-computed expectations from a linear stimulus sequence.
module tb_stream_pattern_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  out_data;
    logic        out_dv, out_sop, out_eop, out_fv;
    logic [2:0]  addr = 3'd0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [31:0] datawr = 32'd0;
    logic [31:0] datard;

    int checks = 0;
    int failures = 0;

    stream_pattern_gen dut (
        .clk_proc   (clk),
        .reset_n    (reset_n),
        .out_data   (out_data),
        .out_dv     (out_dv),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .out_fv     (out_fv),
        .addr_rel_i (addr),
        .wr_i       (wr),
        .datawr_i   (datawr),
        .rd_i       (rd),
        .datard_o   (datard)
    );

    always #5 clk = ~clk;

    // Stream capture
    int         cyc = 0;
    int         sop_total = 0;
    int         eop_total = 0;
    logic [7:0] dq[$];
    int         cq[$];
    bit         sq[$];
    bit         eq[$];

    always @(negedge clk) begin
        cyc++;
        if (out_sop) sop_total++;
        if (out_eop) eop_total++;
        if (out_dv) begin
            dq.push_back(out_data);
            cq.push_back(cyc);
            sq.push_back(out_sop);
            eq.push_back(out_eop);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        addr = a; datawr = d; wr = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        addr = a; rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
        d = datard;
    endtask

    task automatic reg_rdwr(input logic [2:0] a, input logic [31:0] dw, output logic [31:0] d);
        @(posedge clk); #1;
        addr = a; datawr = dw; wr = 1'b1; rd = 1'b1;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
        d = datard;
    endtask

    task automatic wait_eop(input int budget, output bit ok);
        int e0;
        e0 = eop_total;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (eop_total != e0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_sop(input int budget, output bit ok);
        int s0;
        s0 = sop_total;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (sop_total != s0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Counts pixels whose sop/eop flags differ from "sop only first, eop only last"
    task automatic flag_errs(input int b, input int n, output int errs);
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (sq[b+i] != (i == 0)) errs++;
            if (eq[b+i] != (i == n - 1)) errs++;
        end
    endtask

    task automatic check_defaults(input string tag);
        logic [31:0] v;
        logic [31:0] exp_regs[8];
        exp_regs = '{32'd0, 32'd320, 32'd10, 32'd100, 32'd23, 32'd6, 32'd0, 32'd0};
        for (int a = 0; a < 8; a++) begin
            reg_rd(3'(a), v);
            chk($sformatf("%s_reg%0d", tag, a), v, exp_regs[a]);
        end
    endtask

    logic [31:0] v;
    bit          ok;
    int          b, n, errs, s0, e0;
    logic [15:0] lfsr;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dv", {31'd0, out_dv}, 32'd0);
        chk("rst_fv", {31'd0, out_fv}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_datard", datard, 32'd0);
        reset_n = 1'b1;
        check_defaults("def");

        // 1: defaults, continuous ramp
        b = dq.size();
        s0 = sop_total;
        reg_wr(3'd0, 32'h3);
        wait_eop(30000, ok);
        chk("t1_eop_seen", {31'd0, ok}, 32'd1);
        n = dq.size() - b;
        chk("t1_dv_count", n, 32'd3200);
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (dq[b+i] !== 8'(i)) errs++;
            if (i % 320 != 0 && cq[b+i] - cq[b+i-1] != 6) errs++;
        end
        chk("t1_data_spacing_errs", errs, 32'd0);
        flag_errs(b, n, errs);
        chk("t1_flag_errs", errs, 32'd0);
        chk("t1_sop_once", sop_total - s0, 32'd1);
        wait_sop(3000, ok);
        chk("t1_next_sop_seen", {31'd0, ok}, 32'd1);
        chk("t1_frame_gap", cq[b+n] - cq[b+n-1], 32'd1482);
        reg_rd(3'd7, v);
        chk("t1_frames", v, 32'd1);

        // 6: asynchronous reset in the middle of a line
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_dv) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_dv_seen", {31'd0, ok}, 32'd1);
        chk("t6_fv_before", {31'd0, out_fv}, 32'd1);
        e0 = eop_total;
        #1 reset_n = 1'b0;
        #1;
        chk("t6_dv_async", {31'd0, out_dv}, 32'd0);
        chk("t6_fv_async", {31'd0, out_fv}, 32'd0);
        chk("t6_data_async", {24'd0, out_data}, 32'd0);
        chk("t6_datard_async", datard, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        chk("t6_no_eop", eop_total - e0, 32'd0);
        check_defaults("t6");

        // 2: 4x2 gradient, no blanking, DIV=1, single frame
        reg_wr(3'd1, 32'd4);
        reg_wr(3'd2, 32'd2);
        reg_wr(3'd3, 32'd0);
        reg_wr(3'd4, 32'd0);
        reg_wr(3'd5, 32'd1);
        b = dq.size();
        reg_wr(3'd0, 32'h9);
        wait_eop(200, ok);
        chk("t2_eop_seen", {31'd0, ok}, 32'd1);
        n = dq.size() - b;
        chk("t2_dv_count", n, 32'd8);
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (dq[b+i] !== 8'(i % 4)) errs++;
            if (cq[b+i] != cq[b] + i) errs++;
        end
        chk("t2_data_consec_errs", errs, 32'd0);
        flag_errs(b, n, errs);
        chk("t2_flag_errs", errs, 32'd0);
        reg_rd(3'd0, v);
        chk("t2_scr", v, 32'h8);
        reg_rd(3'd7, v);
        chk("t2_frames", v, 32'd1);

        // LFSR: 3x1, DIV=0 behaves as 1
        reg_wr(3'd1, 32'd3);
        reg_wr(3'd2, 32'd1);
        reg_wr(3'd5, 32'd0);
        b = dq.size();
        reg_wr(3'd0, 32'h5);
        wait_eop(100, ok);
        chk("lfsr_eop_seen", {31'd0, ok}, 32'd1);
        chk("lfsr_dv_count", dq.size() - b, 32'd3);
        chk("lfsr_first", {24'd0, dq[b]}, 32'hE1);
        lfsr = 16'hACE1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lfsr_px%0d", i), {24'd0, dq[b+i]}, {24'd0, lfsr[7:0]});
            lfsr = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
        end
        chk("lfsr_consec", cq[b+2] - cq[b], 32'd2);

        // Constant pattern
        reg_wr(3'd6, 32'h5A);
        reg_wr(3'd1, 32'd2);
        b = dq.size();
        reg_wr(3'd0, 32'hD);
        wait_eop(100, ok);
        chk("const_eop_seen", {31'd0, ok}, 32'd1);
        chk("const_dv_count", dq.size() - b, 32'd2);
        chk("const_px0", {24'd0, dq[b]}, 32'h5A);
        chk("const_px1", {24'd0, dq[b+1]}, 32'h5A);

        // 3: single frame with blanking, DIV=2
        reg_wr(3'd7, 32'hFFFF);
        reg_wr(3'd1, 32'd4);
        reg_wr(3'd2, 32'd2);
        reg_wr(3'd3, 32'd1);
        reg_wr(3'd4, 32'd1);
        reg_wr(3'd5, 32'd2);
        b = dq.size();
        reg_wr(3'd0, 32'h1);
        wait_eop(300, ok);
        chk("t3_eop_seen", {31'd0, ok}, 32'd1);
        n = dq.size() - b;
        chk("t3_dv_count", n, 32'd8);
        errs = 0;
        for (int i = 0; i < n; i++) begin
            if (dq[b+i] !== 8'(i)) errs++;
        end
        chk("t3_data_errs", errs, 32'd0);
        chk("t3_spacing_in_line", cq[b+1] - cq[b], 32'd2);
        chk("t3_spacing_line_wrap", cq[b+4] - cq[b+3], 32'd4);
        repeat (30) @(negedge clk);
        #2;
        chk("t3_no_more_dv", dq.size() - b, 32'd8);
        chk("t3_fv_low", {31'd0, out_fv}, 32'd0);
        reg_rd(3'd0, v);
        chk("t3_scr", v, 32'h0);
        reg_rd(3'd7, v);
        chk("t3_frames", v, 32'd1);

        // 4: clear enable at pixel 100 of a continuous 20x10 frame
        reg_wr(3'd1, 32'd20);
        reg_wr(3'd2, 32'd10);
        reg_wr(3'd3, 32'd2);
        reg_wr(3'd4, 32'd1);
        reg_wr(3'd5, 32'd1);
        b = dq.size();
        s0 = sop_total;
        reg_wr(3'd0, 32'h3);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #2;
            if (dq.size() - b >= 100) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_px100_seen", {31'd0, ok}, 32'd1);
        reg_wr(3'd0, 32'h2);
        wait_eop(2000, ok);
        chk("t4_eop_seen", {31'd0, ok}, 32'd1);
        n = dq.size() - b;
        chk("t4_dv_count", n, 32'd200);
        flag_errs(b, n, errs);
        chk("t4_flag_errs", errs, 32'd0);
        repeat (300) @(negedge clk);
        #2;
        chk("t4_no_more_dv", dq.size() - b, 32'd200);
        chk("t4_single_sop", sop_total - s0, 32'd1);
        chk("t4_fv_low", {31'd0, out_fv}, 32'd0);
        reg_rd(3'd0, v);
        chk("t4_scr", v, 32'h2);
        reg_rd(3'd7, v);
        chk("t4_frames", v, 32'd2);

        // Same-cycle read and write returns the old value
        reg_rdwr(3'd1, 32'd7, v);
        chk("rw_old_value", v, 32'd20);
        reg_rd(3'd1, v);
        chk("rw_new_value", v, 32'd7);

        // 5: COLS=0 with enable
        reg_wr(3'd1, 32'd0);
        b = dq.size();
        reg_wr(3'd0, 32'h1);
        repeat (10) @(negedge clk);
        #2;
        chk("t5_no_dv", dq.size() - b, 32'd0);
        reg_rd(3'd0, v);
        chk("t5_cfg_err", v, 32'h10);
        reg_wr(3'd0, 32'h10);
        reg_rd(3'd0, v);
        chk("t5_w1c", v, 32'h0);
        // ROWS=0 flags the same way
        reg_wr(3'd1, 32'd4);
        reg_wr(3'd2, 32'd0);
        reg_wr(3'd0, 32'h1);
        repeat (5) @(negedge clk);
        reg_rd(3'd0, v);
        chk("t5_rows_zero", v, 32'h10);
        chk("t5_no_dv_rows", dq.size() - b, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
